// File: rtl/cpu7_memwb_pipe_pkg.sv
// -----------------------------------------------------------------------------
// cpu7_memwb_pipe_pkg
// Shared definitions for the cpu7 post-EX pipeline backbone:
//   - CPU7_XLEN / CPU7_RFIDX_WIDTH : default datapath and register-index widths,
//     used as parameter defaults by every module of the slice.
//   - fwd_src_e                    : which source feeds a forwarded operand.
//   - fwd_pick()                   : priority encoder for the forwarding mux.
// -----------------------------------------------------------------------------
package cpu7_memwb_pipe_pkg;

    localparam int CPU7_XLEN        = 32;
    localparam int CPU7_RFIDX_WIDTH = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_src_e;

    // Highest priority first: x0 always reads the register file, then the
    // younger MEM result, then the older WB result.
    function automatic fwd_src_e fwd_pick(input logic src_zero,
                                          input logic mem_hit,
                                          input logic wb_hit);
        fwd_src_e sel;
        if (src_zero)     sel = FWD_RF;
        else if (mem_hit) sel = FWD_MEM;
        else if (wb_hit)  sel = FWD_WB;
        else              sel = FWD_RF;
        return sel;
    endfunction

endpackage

// File: rtl/cpu7_memwb_pipe_if.sv
// -----------------------------------------------------------------------------
// cpu7_memwb_pipe_if
// Bundles the EX-side inputs, the load-return handshake and the pipeline
// outputs of cpu7_memwb_pipe.
//   master : the environment (EX stage, data memory, register file)
//   slave  : the pipeline backbone itself
// Signals:
//   ex_valid_i/ex_we_i/ex_load_i/ex_rd_i/ex_result_i : instruction in EX
//   ex_rs1_i/ex_rs2_i/ex_rs1_val_i/ex_rs2_val_i       : EX sources + RF data
//   flush_i                                           : kill EX instruction
//   mem_rvalid_i/mem_rdata_i                          : load data return
//   fwd_rs1_o/fwd_rs2_o                               : forwarded operands
//   stall_o                                           : hold EX and earlier
//   mem_valid_o/mem_load_o                            : MEM slot status
//   wb_we_o/wb_rd_o/wb_data_o                         : register-file write
// -----------------------------------------------------------------------------
interface cpu7_memwb_pipe_if
    import cpu7_memwb_pipe_pkg::*;
#(
    parameter int XLEN        = CPU7_XLEN,
    parameter int RFIDX_WIDTH = CPU7_RFIDX_WIDTH
);
    logic                   ex_valid_i;
    logic                   ex_we_i;
    logic                   ex_load_i;
    logic [RFIDX_WIDTH-1:0] ex_rd_i;
    logic [XLEN-1:0]        ex_result_i;
    logic [RFIDX_WIDTH-1:0] ex_rs1_i;
    logic [RFIDX_WIDTH-1:0] ex_rs2_i;
    logic [XLEN-1:0]        ex_rs1_val_i;
    logic [XLEN-1:0]        ex_rs2_val_i;
    logic                   flush_i;
    logic                   mem_rvalid_i;
    logic [XLEN-1:0]        mem_rdata_i;
    logic [XLEN-1:0]        fwd_rs1_o;
    logic [XLEN-1:0]        fwd_rs2_o;
    logic                   stall_o;
    logic                   mem_valid_o;
    logic                   mem_load_o;
    logic                   wb_we_o;
    logic [RFIDX_WIDTH-1:0] wb_rd_o;
    logic [XLEN-1:0]        wb_data_o;

    modport master (
        output ex_valid_i, ex_we_i, ex_load_i, ex_rd_i, ex_result_i,
               ex_rs1_i, ex_rs2_i, ex_rs1_val_i, ex_rs2_val_i,
               flush_i, mem_rvalid_i, mem_rdata_i,
        input  fwd_rs1_o, fwd_rs2_o, stall_o, mem_valid_o, mem_load_o,
               wb_we_o, wb_rd_o, wb_data_o
    );

    modport slave (
        input  ex_valid_i, ex_we_i, ex_load_i, ex_rd_i, ex_result_i,
               ex_rs1_i, ex_rs2_i, ex_rs1_val_i, ex_rs2_val_i,
               flush_i, mem_rvalid_i, mem_rdata_i,
        output fwd_rs1_o, fwd_rs2_o, stall_o, mem_valid_o, mem_load_o,
               wb_we_o, wb_rd_o, wb_data_o
    );

endinterface

// File: rtl/cpu7_memwb_pipe_fwd_sel.sv
// -----------------------------------------------------------------------------
// cpu7_fwd_sel
// Combinational priority forwarding select for one EX operand.
// Ports:
//   src_i        : EX source register index
//   rf_val_i     : register-file read data for src_i
//   mem_fwd_en_i : MEM slot is live and writes a register
//   mem_rd_i     : MEM destination index
//   mem_val_i    : MEM result (ALU result or load data)
//   wb_fwd_en_i  : WB slot is committing a write (already excludes x0)
//   wb_rd_i      : WB destination index
//   wb_val_i     : WB write data
//   fwd_o        : selected operand
// -----------------------------------------------------------------------------
module cpu7_fwd_sel
    import cpu7_memwb_pipe_pkg::*;
#(
    parameter int XLEN        = CPU7_XLEN,
    parameter int RFIDX_WIDTH = CPU7_RFIDX_WIDTH
) (
    input  logic [RFIDX_WIDTH-1:0] src_i,
    input  logic [XLEN-1:0]        rf_val_i,
    input  logic                   mem_fwd_en_i,
    input  logic [RFIDX_WIDTH-1:0] mem_rd_i,
    input  logic [XLEN-1:0]        mem_val_i,
    input  logic                   wb_fwd_en_i,
    input  logic [RFIDX_WIDTH-1:0] wb_rd_i,
    input  logic [XLEN-1:0]        wb_val_i,
    output logic [XLEN-1:0]        fwd_o
);

    logic     src_zero;
    logic     mem_hit;
    logic     wb_hit;
    fwd_src_e sel;

    always_comb begin
        src_zero = (src_i == '0);
        mem_hit  = mem_fwd_en_i & (mem_rd_i == src_i);
        wb_hit   = wb_fwd_en_i & (wb_rd_i == src_i);
        sel      = fwd_pick(src_zero, mem_hit, wb_hit);
    end

    always_comb begin
        fwd_o = rf_val_i;
        case (sel)
            FWD_MEM: fwd_o = mem_val_i;
            FWD_WB:  fwd_o = wb_val_i;
            default: fwd_o = rf_val_i;
        endcase
    end

endmodule

// File: rtl/cpu7_memwb_pipe.sv
// -----------------------------------------------------------------------------
// cpu7_memwb_pipe
// Post-EX pipeline backbone for cpu7: MEM and WB registers with valid bits,
// priority forwarding (MEM, then WB) into both EX operands, and a
// variable-latency load-return handshake that drives the upstream stall and
// lets a flush arriving during a stall kill the held EX instruction.
// Parameters:
//   XLEN, RFIDX_WIDTH : datapath / register index widths
//   WB_FWD            : 1 = forward from WB as well as MEM, 0 = MEM only
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous, active-high
//   bus   : cpu7_memwb_pipe_if.slave (EX inputs, load return, outputs)
//   stall_cnt_o : saturating stall-cycle counter, present only when the
//                 CPU7_PIPE_PERF_EN macro is defined
// -----------------------------------------------------------------------------
module cpu7_memwb_pipe
    import cpu7_memwb_pipe_pkg::*;
#(
    parameter int XLEN        = CPU7_XLEN,
    parameter int RFIDX_WIDTH = CPU7_RFIDX_WIDTH,
    parameter bit WB_FWD      = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    cpu7_memwb_pipe_if.slave  bus
`ifdef CPU7_PIPE_PERF_EN
    ,
    output logic [31:0]       stall_cnt_o
`endif
);

    // MEM stage
    logic                   mem_valid_q, mem_valid_d;
    logic                   mem_we_q, mem_we_d;
    logic                   mem_load_q, mem_load_d;
    logic [RFIDX_WIDTH-1:0] mem_rd_q, mem_rd_d;
    logic [XLEN-1:0]        mem_result_q, mem_result_d;
    logic                   load_done_q, load_done_d;
    logic [XLEN-1:0]        load_buf_q, load_buf_d;
    logic                   kill_pend_q, kill_pend_d;

    // WB stage; wb_we_q already folds WB valid, rd write enable and rd != 0
    logic                   wb_we_q, wb_we_d;
    logic [RFIDX_WIDTH-1:0] wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]        wb_data_q, wb_data_d;

    logic [XLEN-1:0]        mem_value;
    logic                   mem_ready;
    logic                   stall;
    logic                   load_wait;

    always_comb begin
        if (mem_load_q)
            mem_value = load_done_q ? load_buf_q : bus.mem_rdata_i;
        else
            mem_value = mem_result_q;
        mem_ready = ~mem_load_q | load_done_q | bus.mem_rvalid_i;
        stall     = mem_valid_q & ~mem_ready;
        load_wait = mem_valid_q & mem_load_q & ~load_done_q;
    end

    always_comb begin
        mem_valid_d  = mem_valid_q;
        mem_we_d     = mem_we_q;
        mem_load_d   = mem_load_q;
        mem_rd_d     = mem_rd_q;
        mem_result_d = mem_result_q;
        load_done_d  = load_done_q;
        load_buf_d   = load_buf_q;
        kill_pend_d  = kill_pend_q;
        wb_we_d      = wb_we_q;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;

        if (!stall) begin
            // A flush seen during an earlier stall kills the instruction EX
            // has been holding since then.
            mem_valid_d  = bus.ex_valid_i & ~bus.flush_i & ~kill_pend_q;
            mem_we_d     = bus.ex_we_i;
            mem_load_d   = bus.ex_load_i;
            mem_rd_d     = bus.ex_rd_i;
            mem_result_d = bus.ex_result_i;
            load_done_d  = 1'b0;
            kill_pend_d  = 1'b0;
            // A load beat arriving now goes straight to WB through mem_value.
            wb_we_d      = mem_valid_q & mem_we_q & (mem_rd_q != '0);
            // rd/data only change on a real write so they hold otherwise.
            if (wb_we_d) begin
                wb_rd_d   = mem_rd_q;
                wb_data_d = mem_value;
            end
        end else begin
            wb_we_d = 1'b0;
            if (bus.flush_i)
                kill_pend_d = 1'b1;
            // Beat that cannot advance is parked in load_buf. Extra beats
            // (load_done set, or no load in MEM) fall through untouched.
            if (load_wait && bus.mem_rvalid_i) begin
                load_done_d = 1'b1;
                load_buf_d  = bus.mem_rdata_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_load_q   <= 1'b0;
            mem_rd_q     <= '0;
            mem_result_q <= '0;
            load_done_q  <= 1'b0;
            load_buf_q   <= '0;
            kill_pend_q  <= 1'b0;
            wb_we_q      <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
        end else begin
            mem_valid_q  <= mem_valid_d;
            mem_we_q     <= mem_we_d;
            mem_load_q   <= mem_load_d;
            mem_rd_q     <= mem_rd_d;
            mem_result_q <= mem_result_d;
            load_done_q  <= load_done_d;
            load_buf_q   <= load_buf_d;
            kill_pend_q  <= kill_pend_d;
            wb_we_q      <= wb_we_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
        end
    end

    // Forwarding: one select per EX operand
    logic [RFIDX_WIDTH-1:0] op_src [2];
    logic [XLEN-1:0]        op_rf  [2];
    logic [XLEN-1:0]        op_fwd [2];
    logic                   mem_fwd_en;
    logic                   wb_fwd_en;

    always_comb begin
        op_src[0]  = bus.ex_rs1_i;
        op_src[1]  = bus.ex_rs2_i;
        op_rf[0]   = bus.ex_rs1_val_i;
        op_rf[1]   = bus.ex_rs2_val_i;
        mem_fwd_en = mem_valid_q & mem_we_q;
        wb_fwd_en  = WB_FWD & wb_we_q;
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            cpu7_fwd_sel #(
                .XLEN        (XLEN),
                .RFIDX_WIDTH (RFIDX_WIDTH)
            ) u_fwd_sel (
                .src_i        (op_src[gi]),
                .rf_val_i     (op_rf[gi]),
                .mem_fwd_en_i (mem_fwd_en),
                .mem_rd_i     (mem_rd_q),
                .mem_val_i    (mem_value),
                .wb_fwd_en_i  (wb_fwd_en),
                .wb_rd_i      (wb_rd_q),
                .wb_val_i     (wb_data_q),
                .fwd_o        (op_fwd[gi])
            );
        end
    endgenerate

    assign bus.fwd_rs1_o   = op_fwd[0];
    assign bus.fwd_rs2_o   = op_fwd[1];
    assign bus.stall_o     = stall;
    assign bus.mem_valid_o = mem_valid_q;
    assign bus.mem_load_o  = load_wait;
    assign bus.wb_we_o     = wb_we_q;
    assign bus.wb_rd_o     = wb_rd_q;
    assign bus.wb_data_o   = wb_data_q;

`ifdef CPU7_PIPE_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt_q <= 32'd0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
